// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock-enable generator.
// Produces a divided square wave clk_o (period N, high time H, both in clk
// cycles), a one-cycle tick_o on every rising phase and a wrapping tick
// counter. New N/H values arrive through a valid/ready handshake and only
// take effect at a period boundary, so clk_o never produces a runt pulse.
// Optional feature macro: CLK_DIV_FALL_TICK_EN adds fall_tick_o, a
// one-cycle pulse coincident with every clk_o 1->0 transition.
module clk_div_prog #(
   parameter int CNT_W = 8,
   parameter int EVT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_i,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [CNT_W-1:0] cfg_div_i,
   input  logic [CNT_W-1:0] cfg_high_i,
   output logic             cfg_err_o,
   output logic             clk_o,
   output logic             tick_o,
   output logic [EVT_W-1:0] evt_cnt_o,
   output logic             busy_o
`ifdef CLK_DIV_FALL_TICK_EN
   ,
   output logic             fall_tick_o
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_phase;
   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] r_high;
   logic             r_pend_vld;
   logic [CNT_W-1:0] r_pend_div;
   logic [CNT_W-1:0] r_pend_high;
   logic             r_clk;
   logic             r_tick;
   logic [EVT_W-1:0] r_evt;
   logic             r_err;
`ifdef CLK_DIV_FALL_TICK_EN
   logic             r_fall;
`endif

   logic             w_accept;
   logic             w_legal;
   logic             w_active;
   logic             w_wrap;

   // A config is usable only if the period has room for both a high and a
   // low phase: N >= 2 and 1 <= H <= N-1.
   function automatic logic cfg_legal(input logic [CNT_W-1:0] n,
                                      input logic [CNT_W-1:0] h);
      return (n >= CNT_W'(2)) && (h != '0) && (h < n);
   endfunction

   assign w_accept = cfg_valid_i & ~r_pend_vld;
   assign w_legal  = cfg_legal(cfg_div_i, cfg_high_i);
   assign w_active = (r_state != ST_IDLE);
   // Active N is always >= 2, so N-1 never underflows.
   assign w_wrap   = (r_phase == (r_div - CNT_W'(1)));

   // Config path: direct load while idle, single pending slot while running,
   // pending slot promoted to the active registers on the wrap cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div      <= CNT_W'(2);
         r_high     <= CNT_W'(1);
         r_pend_vld <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_accept & ~w_legal;
         if (w_accept && w_legal) begin
            if (r_state == ST_IDLE) begin
               r_div  <= cfg_div_i;
               r_high <= cfg_high_i;
            end else begin
               r_pend_div  <= cfg_div_i;
               r_pend_high <= cfg_high_i;
               r_pend_vld  <= 1'b1;
            end
         end
         // Only a slot that was already full before this edge is applied, so
         // a config accepted on the wrap edge waits for the following wrap.
         if (w_active && w_wrap && r_pend_vld) begin
            r_div      <= r_pend_div;
            r_high     <= r_pend_high;
            r_pend_vld <= 1'b0;
         end
      end
   end

   // Run/drain FSM with phase counter and registered waveform outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_phase <= '0;
         r_clk   <= 1'b0;
         r_tick  <= 1'b0;
         r_evt   <= '0;
`ifdef CLK_DIV_FALL_TICK_EN
         r_fall  <= 1'b0;
`endif
      end else begin
         r_tick <= 1'b0;
`ifdef CLK_DIV_FALL_TICK_EN
         r_fall <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               r_phase <= '0;
               if (run_i) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN, ST_DRAIN: begin
               // New rises only while running; drain just finishes the period.
               if ((r_phase == '0) && (r_state == ST_RUN)) begin
                  r_clk  <= 1'b1;
                  r_tick <= 1'b1;
                  r_evt  <= r_evt + EVT_W'(1);
               end
               if (r_phase == r_high) begin
                  r_clk  <= 1'b0;
`ifdef CLK_DIV_FALL_TICK_EN
                  r_fall <= r_clk;
`endif
               end
               r_phase <= w_wrap ? '0 : (r_phase + CNT_W'(1));
               if (r_state == ST_RUN) begin
                  if (!run_i) begin
                     r_state <= ST_DRAIN;
                  end
               end else begin
                  if (run_i) begin
                     r_state <= ST_RUN;
                  end else if (w_wrap) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_phase <= '0;
               r_clk   <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready_o = ~r_pend_vld;
   assign cfg_err_o   = r_err;
   assign clk_o       = r_clk;
   assign tick_o      = r_tick;
   assign evt_cnt_o   = r_evt;
   assign busy_o      = w_active;
`ifdef CLK_DIV_FALL_TICK_EN
   assign fall_tick_o = r_fall;
`endif

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock-enable generator, successor to the fixed divide-by-4 divider. Produces a divided square wave `clk_o` with programmable period N and high time H, a one-cycle `tick_o` enable on each rising phase, and a wrapping tick counter. Sits beside the system clock tree: downstream logic stays on `clk` and qualifies with `tick_o`. Config is loaded through a valid/ready handshake and takes effect only on period boundaries, so no runt pulses.

## Interface
- `CNT_W`, 8: width of period/high-time fields and phase counter.
- `EVT_W`, 3: width of tick counter `evt_cnt_o`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `run_i`  in  1  level; 1 = generate, 0 = stop at end of current period.
- `cfg_valid_i`  in  1  config offer.
- `cfg_ready_o`  out  1  config slot free.
- `cfg_div_i`  in  CNT_W  period N in `clk` cycles.
- `cfg_high_i`  in  CNT_W  high time H in `clk` cycles.
- `cfg_err_o`  out  1  one-cycle pulse: accepted config was illegal, discarded.
- `clk_o`  out  1  divided output, registered.
- `tick_o`  out  1  one-cycle pulse coincident with `clk_o` rising.
- `evt_cnt_o`  out  EVT_W  count of `tick_o` pulses, wraps modulo 2^EVT_W.
- `busy_o`  out  1  state != IDLE.
- `fall_tick_o`  out  1  only with `CLK_DIV_FALL_TICK_EN`.

## Operation
- Reset: state IDLE, active N=2 H=1, no pending cfg, phase_cnt=0, `clk_o`=0, `tick_o`=0, `evt_cnt_o`=0, `cfg_ready_o`=1, `cfg_err_o`=0, `fall_tick_o`=0. Reset mid-period kills the period immediately; pending cfg discarded.
- Legal cfg: N >= 2 and 1 <= H <= N-1. Illegal cfg: handshake completes, cfg discarded, `cfg_err_o` pulses the next cycle, active cfg unchanged.
- Handshake: accept on `cfg_valid_i & cfg_ready_o`. In IDLE a legal cfg writes the active registers directly; `cfg_ready_o` stays 1. In RUN/DRAIN it goes into a single pending slot; `cfg_ready_o`=0 until the pending cfg is applied at the next wrap.
- FSM:
  - IDLE: on `run_i`=1 -> RUN, phase_cnt=0.
  - RUN: `run_i`=0 -> DRAIN.
  - DRAIN: `run_i`=1 -> RUN, no gap. Wrap -> IDLE.
- Counting in RUN/DRAIN, phase_cnt 0..N-1, wraps to 0 after N-1.
  - phase_cnt==0 in RUN: `clk_o`<=1, `tick_o`<=1, `evt_cnt_o`+=1.
  - phase_cnt==0 in DRAIN: no new rise; `clk_o` stays 0.
  - phase_cnt==H: `clk_o`<=0.
- Wrap is phase_cnt==N-1. Pending cfg applied there; the next period uses the new N/H.
- Compare against the active N/H only. A cfg accepted on the same edge as a wrap is applied at the following wrap.
- DRAIN completes the current period. `clk_o` is 0 at IDLE entry, since H <= N-1.

## Timing
- `run_i` sampled 1 at edge t in IDLE: RUN at t, first `clk_o`/`tick_o` high after edge t+1 (2-cycle latency).
- `clk_o` high exactly H cycles, period exactly N cycles; `tick_o` every N cycles.
- `cfg_err_o` asserted the cycle after the accepting edge.
- Max N = 2^CNT_W - 1. Arithmetic unsigned, no overflow.

## Configuration
- `CLK_DIV_FALL_TICK_EN` defined: port `fall_tick_o` exists and pulses one cycle coincident with each `clk_o` 1->0 transition, including the final fall in DRAIN.
- Not defined: port and logic absent; all other behaviour identical.

## Test plan
- Reset, `run_i`=1, default cfg -> `clk_o` toggles every cycle (N=2, H=1); `tick_o` every 2 cycles; `evt_cnt_o` wraps 7->0 after 8 ticks.
- In IDLE, load N=5 H=2, then run -> `clk_o` high 2 low 3 repeating; first rise 2 cycles after `run_i`.
- While running at N=5 H=2, load N=8 H=6 -> `cfg_ready_o`=0 until wrap; current period finishes at 5; next periods are 8/6; `cfg_ready_o` returns to 1.
- Load N=4 H=4, then N=1 H=0 -> each `cfg_err_o` pulses once; output unchanged.
- N=6 H=3: drop `run_i` at phase 1 -> period completes, IDLE after wrap, `clk_o`=0, `busy_o`=0. Re-raise `run_i` during DRAIN -> continuous.
- Assert `rst` mid-high-phase with a pending cfg -> next cycle all outputs at reset values; pending cfg lost.
